// File: rtl/dealer_pkg.sv
// Card, deck and dealer state types shared by the dealer and the seat blocks.
package dealer_pkg;

    typedef enum logic [1:0] {
        SUIT_SPADES, SUIT_HEARTS, SUIT_DIAMONDS, SUIT_CLUBS
    } suit_t;

    typedef enum logic [3:0] {
        RANK_TWO, RANK_THREE, RANK_FOUR, RANK_FIVE, RANK_SIX, RANK_SEVEN, RANK_EIGHT,
        RANK_NINE, RANK_TEN, RANK_JACK, RANK_QUEEN, RANK_KING, RANK_ACE
    } rank_t;

    typedef struct packed {
        suit_t suit;
        rank_t rank;
    } card_t;

    typedef enum logic [2:0] {
        DS_IDLE, DS_INIT, DS_SHUFFLE, DS_DEAL_HOLE, DS_BOARD_WAIT, DS_DEAL_BOARD, DS_HAND_DONE
    } dealer_state_t;

    localparam int          DECK_SIZE     = 52;
    localparam int          BURN_CARDS    = 1;
    localparam logic [15:0] LFSR_DEFAULT  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam card_t       ACE_OF_SPADES = '{suit: SUIT_SPADES, rank: RANK_ACE};

    // rank = idx mod 13 computed in 4 bits: subtract (13*suit) mod 16, which is exact since rank < 13
    function automatic card_t idx_to_card(input logic [5:0] idx);
        card_t      c;
        logic [3:0] off;
        if (idx >= 6'd39) begin
            c.suit = SUIT_CLUBS;
            off    = 4'd7;
        end else if (idx >= 6'd26) begin
            c.suit = SUIT_DIAMONDS;
            off    = 4'd10;
        end else if (idx >= 6'd13) begin
            c.suit = SUIT_HEARTS;
            off    = 4'd13;
        end else begin
            c.suit = SUIT_SPADES;
            off    = 4'd0;
        end
        c.rank = rank_t'(idx[3:0] - off);
        return c;
    endfunction

endpackage

// File: rtl/dealer_lfsr.sv
// Galois LFSR (x^16+x^14+x^13+x^11+1) feeding the shuffle; loads a seed, steps on enable.
module dealer_lfsr
    import dealer_pkg::*;
#(
    parameter int LFSR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_adv,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] r_state;
    logic [LFSR_W-1:0] w_seed;
    logic [LFSR_W-1:0] w_taps;
    logic [LFSR_W-1:0] w_next;

    // an all-zero state would lock the LFSR, so substitute the default
    assign w_seed  = (i_seed == '0) ? LFSR_W'(LFSR_DEFAULT) : i_seed;
    assign w_taps  = LFSR_W'(LFSR_TAPS);
    assign w_next  = (r_state >> 1) ^ (r_state[0] ? w_taps : '0);
    assign o_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LFSR_W'(LFSR_DEFAULT);
        end else if (i_load) begin
            r_state <= w_seed;
        end else if (i_adv) begin
            r_state <= w_next;
        end
    end

endmodule

// File: rtl/dealer.sv
// Deck owner: builds, Fisher-Yates shuffles and deals hole cards per seat, then burn+flop/turn/river.
// DEALER_FIXED_DECK_EN skips the shuffle and ignores seed, so cards come out in index order.
module dealer
    import dealer_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int LFSR_W      = 16
) (
    input  logic                   clk,
    input  logic                   dealer_reset,
    input  logic [LFSR_W-1:0]      seed,
    input  logic                   start_hand,
    input  logic                   deal_board,
    output logic                   busy,
    output card_t [1:0]            hole_cards,
    output logic [NUM_PLAYERS-1:0] set_cards,
    output card_t [4:0]            board,
    output logic [2:0]             board_count,
    output logic                   hand_done
);

    localparam logic [2:0] ST_IDLE       = DS_IDLE;
    localparam logic [2:0] ST_INIT       = DS_INIT;
    localparam logic [2:0] ST_SHUFFLE    = DS_SHUFFLE;
    localparam logic [2:0] ST_DEAL_HOLE  = DS_DEAL_HOLE;
    localparam logic [2:0] ST_BOARD_WAIT = DS_BOARD_WAIT;
    localparam logic [2:0] ST_DEAL_BOARD = DS_DEAL_BOARD;
    localparam logic [2:0] ST_HAND_DONE  = DS_HAND_DONE;

    logic [2:0]  r_state;
    logic [5:0]  r_cnt;
    logic [5:0]  r_ptr;
    logic [3:0]  r_seat;
    logic [5:0]  r_deck [DECK_SIZE];
    card_t [1:0] r_hole;
    card_t [4:0] r_board;
    logic [2:0]  r_board_count;
    logic [2:0]  r_bidx;
    logic        r_burned;

    logic              w_start;
    logic              w_deal;
    logic              w_lfsr_load;
    logic              w_lfsr_adv;
    logic [LFSR_W-1:0] w_lfsr;
    logic [5:0]        w_r;
    logic              w_accept;
    logic [2:0]        w_target;
    card_t             w_card;
    card_t             w_card_nx;

    assign w_start = start_hand && (r_state == ST_IDLE || r_state == ST_HAND_DONE);
    // start_hand is never legal in BOARD_WAIT, so it cannot collide with an accepted deal_board
    assign w_deal  = deal_board && (r_state == ST_BOARD_WAIT);

`ifdef DEALER_FIXED_DECK_EN
    assign w_lfsr_load = 1'b0;
    assign w_lfsr_adv  = 1'b0;
`else
    assign w_lfsr_load = w_start;
    assign w_lfsr_adv  = (r_state == ST_SHUFFLE);
`endif

    dealer_lfsr #(
        .LFSR_W (LFSR_W)
    ) u_lfsr (
        .clk     (clk),
        .rst     (dealer_reset),
        .i_load  (w_lfsr_load),
        .i_seed  (seed),
        .i_adv   (w_lfsr_adv),
        .o_state (w_lfsr)
    );

    assign w_r       = 6'(w_lfsr);
    assign w_accept  = (w_r <= r_cnt);
    assign w_target  = (r_board_count == 3'd0) ? 3'd3 : r_board_count + 3'd1;
    assign w_card    = idx_to_card(r_deck[r_ptr]);
    assign w_card_nx = idx_to_card(r_deck[r_ptr + 6'd1]);

    // deck contents are always rebuilt in INIT before being read, so no reset is needed
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_deck[r_cnt] <= r_cnt;
        end else if (r_state == ST_SHUFFLE && w_accept) begin
            r_deck[r_cnt] <= r_deck[w_r];
            r_deck[w_r]   <= r_deck[r_cnt];
        end
    end

    always_ff @(posedge clk or posedge dealer_reset) begin
        if (dealer_reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_ptr         <= '0;
            r_seat        <= '0;
            r_hole        <= {2{ACE_OF_SPADES}};
            r_board       <= {5{ACE_OF_SPADES}};
            r_board_count <= '0;
            r_bidx        <= '0;
            r_burned      <= 1'b0;
        end else if (w_start) begin
            r_state       <= ST_INIT;
            r_cnt         <= '0;
            r_ptr         <= '0;
            r_board       <= {5{ACE_OF_SPADES}};
            r_board_count <= '0;
            r_bidx        <= '0;
            r_burned      <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'(DECK_SIZE - 1)) begin
`ifdef DEALER_FIXED_DECK_EN
                        r_state <= ST_DEAL_HOLE;
                        r_ptr   <= '0;
                        r_seat  <= '0;
`else
                        r_state <= ST_SHUFFLE;
                        r_cnt   <= 6'(DECK_SIZE - 1);
`endif
                    end
                end
                ST_SHUFFLE: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt - 6'd1;
                        if (r_cnt == 6'd1) begin
                            r_state <= ST_DEAL_HOLE;
                            r_ptr   <= '0;
                            r_seat  <= '0;
                        end
                    end
                end
                ST_DEAL_HOLE: begin
                    r_hole <= {w_card_nx, w_card};
                    r_ptr  <= r_ptr + 6'd2;
                    r_seat <= r_seat + 4'd1;
                    if (r_seat == 4'(NUM_PLAYERS - 1)) begin
                        r_state <= ST_BOARD_WAIT;
                    end
                end
                ST_BOARD_WAIT: begin
                    if (w_deal) begin
                        r_state  <= ST_DEAL_BOARD;
                        r_burned <= 1'b0;
                    end
                end
                ST_DEAL_BOARD: begin
                    if (!r_burned) begin
                        r_ptr    <= r_ptr + 6'(BURN_CARDS);
                        r_burned <= 1'b1;
                    end else begin
                        r_board[r_bidx] <= w_card;
                        r_ptr           <= r_ptr + 6'd1;
                        r_bidx          <= r_bidx + 3'd1;
                        if (r_bidx + 3'd1 == w_target) begin
                            r_board_count <= w_target;
                            r_burned      <= 1'b0;
                            r_state       <= (w_target == 3'd5) ? ST_HAND_DONE : ST_BOARD_WAIT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // strobe and live hole cards come straight from state so a reset kills them immediately
    assign set_cards   = (r_state == ST_DEAL_HOLE) ? (NUM_PLAYERS'(1) << r_seat) : '0;
    assign hole_cards  = (r_state == ST_DEAL_HOLE) ? {w_card_nx, w_card} : r_hole;
    assign busy        = (r_state == ST_INIT) || (r_state == ST_SHUFFLE) ||
                         (r_state == ST_DEAL_HOLE) || (r_state == ST_DEAL_BOARD);
    assign hand_done   = (r_state == ST_HAND_DONE);
    assign board       = r_board;
    assign board_count = r_board_count;

endmodule

// File: tb/tb_dealer.sv
// Directed bench for dealer with a reference Fisher-Yates model of the expected deal.
module tb_dealer;
    import dealer_pkg::*;

    logic        clk = 1'b0;
    logic        dealer_reset;
    logic [15:0] seed;
    logic        start_hand;
    logic        deal_board;
    logic        busy;
    card_t [1:0] hole_cards;
    logic [3:0]  set_cards;
    card_t [4:0] board;
    logic [2:0]  board_count;
    logic        hand_done;

    dealer #(.NUM_PLAYERS(4), .LFSR_W(16)) dut (
        .clk          (clk),
        .dealer_reset (dealer_reset),
        .seed         (seed),
        .start_hand   (start_hand),
        .deal_board   (deal_board),
        .busy         (busy),
        .hole_cards   (hole_cards),
        .set_cards    (set_cards),
        .board        (board),
        .board_count  (board_count),
        .hand_done    (hand_done)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_err    = 0;
    logic [5:0] m_exp  [13];
    logic [5:0] obs    [13];
    logic [5:0] first  [13];
    logic [5:0] zobs   [13];
    logic [3:0] strb   [4];
    logic [2:0] bcs    [3];
    logic [5:0] hold_after [2];
    logic [3:0] post_set;
    logic       hd;
    logic       b_init;
    int         wait_n;
    bit         tmo;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] c2i(input card_t c);
        int v;
        v = int'(c.suit) * 13 + int'(c.rank);
        return v[5:0];
    endfunction

    function automatic logic [15:0] lstep(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic model_deal(input logic [15:0] sd);
        logic [5:0]  dk [52];
        logic [5:0]  r;
        logic [5:0]  t;
        logic [15:0] s;
        int          i;
        for (int k = 0; k < 52; k++) dk[k] = 6'(k);
`ifndef DEALER_FIXED_DECK_EN
        s = (sd == 16'h0) ? 16'hACE1 : sd;
        i = 51;
        while (i > 0) begin
            r = s[5:0];
            s = lstep(s);
            if (int'(r) <= i) begin
                t     = dk[i];
                dk[i] = dk[r];
                dk[r] = t;
                i--;
            end
        end
`else
        s = sd;
        i = int'(s[0]);
`endif
        for (int k = 0; k < 8; k++) m_exp[k] = dk[k];
        m_exp[8]  = dk[9];
        m_exp[9]  = dk[10];
        m_exp[10] = dk[11];
        m_exp[11] = dk[13];
        m_exp[12] = dk[15];
    endtask

    task automatic wait_idle(output bit to);
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        to = busy;
    endtask

    task automatic play_hand(input logic [15:0] sd);
        bit t;
        tmo        = 0;
        seed       = sd;
        start_hand = 1'b1;
        tick();
        start_hand = 1'b0;
        b_init     = busy;
        wait_n     = 0;
        while (set_cards == 4'b0 && wait_n < 3000) begin
            tick();
            wait_n++;
        end
        if (set_cards == 4'b0) begin
            tmo = 1;
            return;
        end
        for (int s = 0; s < 4; s++) begin
            strb[s]        = set_cards;
            obs[2*s]       = c2i(hole_cards[0]);
            obs[2*s+1]     = c2i(hole_cards[1]);
            tick();
        end
        post_set      = set_cards;
        hold_after[0] = c2i(hole_cards[0]);
        hold_after[1] = c2i(hole_cards[1]);
        for (int st = 0; st < 3; st++) begin
            deal_board = 1'b1;
            tick();
            deal_board = 1'b0;
            wait_idle(t);
            if (t) tmo = 1;
            bcs[st] = board_count;
        end
        hd = hand_done;
        for (int b = 0; b < 5; b++) obs[8+b] = c2i(board[b]);
    endtask

    task automatic test_reset();
        dealer_reset = 1'b1;
        start_hand   = 1'b0;
        deal_board   = 1'b0;
        seed         = 16'h0;
        tick();
        tick();
        n_checks++; if (set_cards !== 4'b0) begin n_err++; $display("FAIL reset_set_cards got=%b exp=0000", set_cards); end
        n_checks++; if (board_count !== 3'd0) begin n_err++; $display("FAIL reset_board_count got=%0d exp=0", board_count); end
        n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (hand_done !== 1'b0) begin n_err++; $display("FAIL reset_hand_done got=%b exp=0", hand_done); end
        for (int h = 0; h < 2; h++) begin
            n_checks++; if (hole_cards[h] !== ACE_OF_SPADES) begin n_err++; $display("FAIL reset_hole%0d got=%h exp=%h", h, hole_cards[h], ACE_OF_SPADES); end
        end
        for (int b = 0; b < 5; b++) begin
            n_checks++; if (board[b] !== ACE_OF_SPADES) begin n_err++; $display("FAIL reset_board%0d got=%h exp=%h", b, board[b], ACE_OF_SPADES); end
        end
        dealer_reset = 1'b0;
        tick();
    endtask

    task automatic test_first_hand();
        int dup;
        model_deal(16'h1234);
        play_hand(16'h1234);
        n_checks++; if (tmo !== 1'b0) begin n_err++; $display("FAIL hand1_timeout got=%b exp=0", tmo); end
        n_checks++; if (b_init !== 1'b1) begin n_err++; $display("FAIL hand1_busy_init got=%b exp=1", b_init); end
`ifdef DEALER_FIXED_DECK_EN
        n_checks++; if (wait_n != 52) begin n_err++; $display("FAIL hand1_init_cycles got=%0d exp=52", wait_n); end
`else
        n_checks++; if (wait_n < 103) begin n_err++; $display("FAIL hand1_init_shuffle_cycles got=%0d exp>=103", wait_n); end
`endif
        for (int s = 0; s < 4; s++) begin
            n_checks++; if (strb[s] !== 4'(1 << s)) begin n_err++; $display("FAIL hand1_strobe%0d got=%b exp=%b", s, strb[s], 4'(1 << s)); end
        end
        for (int k = 0; k < 13; k++) begin
            n_checks++; if (obs[k] !== m_exp[k]) begin n_err++; $display("FAIL hand1_card%0d got=%0d exp=%0d", k, obs[k], m_exp[k]); end
        end
        n_checks++; if (post_set !== 4'b0) begin n_err++; $display("FAIL hand1_strobe_end got=%b exp=0000", post_set); end
        n_checks++; if (hold_after[0] !== m_exp[6] || hold_after[1] !== m_exp[7]) begin
            n_err++; $display("FAIL hand1_hole_hold got=%0d/%0d exp=%0d/%0d", hold_after[0], hold_after[1], m_exp[6], m_exp[7]); end
        for (int st = 0; st < 3; st++) begin
            n_checks++; if (bcs[st] !== 3'(st + 3)) begin n_err++; $display("FAIL hand1_board_count%0d got=%0d exp=%0d", st, bcs[st], st + 3); end
        end
        n_checks++; if (hd !== 1'b1) begin n_err++; $display("FAIL hand1_hand_done got=%b exp=1", hd); end
        dup = 0;
        for (int a = 0; a < 13; a++)
            for (int b = a + 1; b < 13; b++)
                if (obs[a] == obs[b]) dup++;
        n_checks++; if (dup != 0) begin n_err++; $display("FAIL hand1_distinct got=%0d duplicate pairs exp=0", dup); end
        for (int k = 0; k < 13; k++) first[k] = obs[k];
    endtask

    task automatic test_repeat();
        play_hand(16'h1234);
        n_checks++; if (tmo !== 1'b0) begin n_err++; $display("FAIL repeat_timeout got=%b exp=0", tmo); end
        for (int k = 0; k < 13; k++) begin
            n_checks++; if (obs[k] !== first[k]) begin n_err++; $display("FAIL repeat_card%0d got=%0d exp=%0d", k, obs[k], first[k]); end
        end
    endtask

    task automatic test_seed_zero();
        model_deal(16'hACE1);
        play_hand(16'h0000);
        n_checks++; if (tmo !== 1'b0) begin n_err++; $display("FAIL seed0_timeout got=%b exp=0", tmo); end
        for (int k = 0; k < 13; k++) begin
            n_checks++; if (obs[k] !== m_exp[k]) begin n_err++; $display("FAIL seed0_card%0d got=%0d exp=%0d", k, obs[k], m_exp[k]); end
            zobs[k] = obs[k];
        end
        play_hand(16'hACE1);
        for (int k = 0; k < 13; k++) begin
            n_checks++; if (obs[k] !== zobs[k]) begin n_err++; $display("FAIL seedace1_card%0d got=%0d exp=%0d", k, obs[k], zobs[k]); end
        end
    endtask

`ifndef DEALER_FIXED_DECK_EN
    task automatic test_diff_seed();
        bit differs;
        model_deal(16'h5678);
        play_hand(16'h5678);
        differs = 0;
        for (int k = 0; k < 13; k++) if (obs[k] != first[k]) differs = 1;
        n_checks++; if (differs !== 1'b1) begin n_err++; $display("FAIL diffseed_differs got=%b exp=1", differs); end
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (obs[k] !== m_exp[k]) begin n_err++; $display("FAIL diffseed_hole%0d got=%0d exp=%0d", k, obs[k], m_exp[k]); end
        end
    endtask
`endif

    task automatic test_illegal_strobes();
        bit t;
        int n = 0;
        model_deal(16'h1234);
        seed       = 16'h1234;
        start_hand = 1'b1;
        tick();
        start_hand = 1'b0;
        while (set_cards == 4'b0 && n < 3000) begin
            tick();
            n++;
        end
        n_checks++; if (set_cards !== 4'b0001) begin n_err++; $display("FAIL illegal_first_strobe got=%b exp=0001", set_cards); return; end
        deal_board = 1'b1;
        start_hand = 1'b1;
        tick();
        n_checks++; if (set_cards !== 4'b0010) begin n_err++; $display("FAIL illegal_strobe1 got=%b exp=0010", set_cards); end
        tick();
        n_checks++; if (set_cards !== 4'b0100) begin n_err++; $display("FAIL illegal_strobe2 got=%b exp=0100", set_cards); end
        deal_board = 1'b0;
        start_hand = 1'b0;
        tick();
        n_checks++; if (set_cards !== 4'b1000) begin n_err++; $display("FAIL illegal_strobe3 got=%b exp=1000", set_cards); end
        tick();
        n_checks++; if (busy !== 1'b0 || board_count !== 3'd0) begin
            n_err++; $display("FAIL illegal_after_hole busy=%b count=%0d exp busy=0 count=0", busy, board_count); end
        start_hand = 1'b1;
        tick();
        start_hand = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0 || set_cards !== 4'b0 || board_count !== 3'd0) begin
            n_err++; $display("FAIL illegal_start_in_wait busy=%b set=%b count=%0d exp 0/0000/0", busy, set_cards, board_count); end
        start_hand = 1'b1;
        deal_board = 1'b1;
        tick();
        start_hand = 1'b0;
        deal_board = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_err++; $display("FAIL illegal_deal_wins got busy=%b exp=1", busy); end
        wait_idle(t);
        n_checks++; if (t !== 1'b0 || board_count !== 3'd3) begin n_err++; $display("FAIL illegal_flop_count got=%0d to=%b exp=3", board_count, t); end
        for (int b = 0; b < 3; b++) begin
            n_checks++; if (c2i(board[b]) !== m_exp[8+b]) begin n_err++; $display("FAIL illegal_flop%0d got=%0d exp=%0d", b, c2i(board[b]), m_exp[8+b]); end
        end
        for (int st = 0; st < 2; st++) begin
            deal_board = 1'b1;
            tick();
            deal_board = 1'b0;
            wait_idle(t);
        end
        n_checks++; if (board_count !== 3'd5 || hand_done !== 1'b1) begin
            n_err++; $display("FAIL illegal_river count=%0d done=%b exp 5/1", board_count, hand_done); end
        start_hand = 1'b1;
        deal_board = 1'b1;
        tick();
        start_hand = 1'b0;
        deal_board = 1'b0;
        n_checks++; if (busy !== 1'b1 || board_count !== 3'd0 || hand_done !== 1'b0 || board[0] !== ACE_OF_SPADES) begin
            n_err++; $display("FAIL illegal_restart busy=%b count=%0d done=%b b0=%h exp 1/0/0/%h", busy, board_count, hand_done, board[0], ACE_OF_SPADES); end
    endtask

    task automatic test_reset_mid();
        int strobes;
        int n;
`ifdef DEALER_FIXED_DECK_EN
        for (int c = 0; c < 30; c++) tick();
`else
        for (int c = 0; c < 60; c++) tick();
`endif
        n_checks++; if (busy !== 1'b1) begin n_err++; $display("FAIL midreset_pre_busy got=%b exp=1", busy); end
        #3 dealer_reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || set_cards !== 4'b0 || board_count !== 3'd0 || hand_done !== 1'b0) begin
            n_err++; $display("FAIL midreset1_outputs busy=%b set=%b count=%0d done=%b exp 0/0000/0/0", busy, set_cards, board_count, hand_done); end
        tick();
        dealer_reset = 1'b0;
        strobes = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (set_cards != 4'b0) strobes++;
        end
        n_checks++; if (strobes != 0) begin n_err++; $display("FAIL midreset1_no_strobe got=%0d strobes exp=0", strobes); end
        seed       = 16'h1234;
        start_hand = 1'b1;
        tick();
        start_hand = 1'b0;
        n = 0;
        while (set_cards != 4'b0010 && n < 3000) begin
            tick();
            n++;
        end
        n_checks++; if (set_cards !== 4'b0010) begin n_err++; $display("FAIL midreset2_reach_seat1 got=%b exp=0010", set_cards); end
        #3 dealer_reset = 1'b1;
        #1;
        n_checks++; if (set_cards !== 4'b0 || busy !== 1'b0 || hole_cards[0] !== ACE_OF_SPADES || hole_cards[1] !== ACE_OF_SPADES) begin
            n_err++; $display("FAIL midreset2_outputs set=%b busy=%b hole=%h/%h exp 0000/0/%h", set_cards, busy, hole_cards[0], hole_cards[1], ACE_OF_SPADES); end
        tick();
        dealer_reset = 1'b0;
        strobes = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (set_cards != 4'b0) strobes++;
        end
        n_checks++; if (strobes != 0) begin n_err++; $display("FAIL midreset2_no_strobe got=%0d strobes exp=0", strobes); end
        play_hand(16'h1234);
        for (int k = 0; k < 13; k++) begin
            n_checks++; if (obs[k] !== first[k]) begin n_err++; $display("FAIL postreset_card%0d got=%0d exp=%0d", k, obs[k], first[k]); end
        end
    endtask

    initial begin
        dealer_reset = 1'b1;
        start_hand   = 1'b0;
        deal_board   = 1'b0;
        seed         = 16'h0;
        test_reset();
        test_first_hand();
        test_repeat();
        test_seed_zero();
`ifndef DEALER_FIXED_DECK_EN
        test_diff_seed();
`endif
        test_illegal_strobes();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
